// File: rtl/mux_sel_arbiter.sv
// Two-source burst arbiter that drives the select of a downstream 2:1 mux.
// Round-robin between sources, up to BURST beats per grant, with no idle bubble on hand-over.
module mux_sel_arbiter #(
    parameter int BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_0,
    input  logic req_1,
    input  logic out_ready,
    output logic sel,
    output logic ready_0,
    output logic ready_1,
    output logic out_valid
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       sel_q;

    logic       own_req;
    logic       other_req;
    logic       xfer;
    logic [3:0] cnt_inc;

    assign out_valid = ((state_q == GNT0) && req_0) || ((state_q == GNT1) && req_1);
    assign ready_0   = (state_q == GNT0) && out_ready;
    assign ready_1   = (state_q == GNT1) && out_ready;
    assign sel       = sel_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        own_req   = (state_q == GNT1) ? req_1 : req_0;
        other_req = (state_q == GNT1) ? req_0 : req_1;
        xfer      = out_valid && out_ready;
        cnt_inc   = cnt_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (req_0) begin
                    state_d = GNT0;
                end else if (req_1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req || (xfer && (cnt_inc == BURST_C))) begin
                    // Hand-over to the other source beats re-grant of the current one.
                    cnt_d = 4'd0;
                    if (other_req) begin
                        state_d = (state_q == GNT0) ? GNT1 : GNT0;
                    end else if (own_req) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (state_d != IDLE) begin
            last_d = (state_d == GNT1);
        end
    end

    // last_q resets to 1 so source 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= (state_d == GNT1);
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: BURST=4 and BURST=1 instances share stimulus and are
// checked every cycle against an owner/beat-count model, plus literal transfer-order checks.
module tb_mux_sel_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic req_0, req_1, out_ready;
    logic a_sel, a_r0, a_r1, a_ov;
    logic b_sel, b_r0, b_r1, b_ov;

    int total = 0;
    int bad   = 0;

    bit logA[$];
    bit logB[$];

    int burst_of [2] = '{4, 1};
    int m_own  [2];
    int m_beats[2];
    int m_last [2];
    int n_own  [2];
    int n_beats[2];
    int n_last [2];
    logic [3:0] dut_out[2];

    always #5 clk = ~clk;

    mux_sel_arbiter #(.BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .out_ready(out_ready),
        .sel(a_sel), .ready_0(a_r0), .ready_1(a_r1), .out_valid(a_ov)
    );

    mux_sel_arbiter #(.BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_0(req_0), .req_1(req_1), .out_ready(out_ready),
        .sel(b_sel), .ready_0(b_r0), .ready_1(b_r1), .out_valid(b_ov)
    );

    assign dut_out[0] = {a_sel, a_ov, a_r0, a_r1};
    assign dut_out[1] = {b_sel, b_ov, b_r0, b_r1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Owner -1 means nobody holds the grant.
    function automatic void mstep(input int own, input int beats, input int last,
                                  input bit r0, input bit r1, input bit rdy, input int b,
                                  output int o_own, output int o_beats, output int o_last);
        bit [1:0] r;
        int nb;
        r       = {r1, r0};
        o_own   = own;
        o_beats = beats;
        o_last  = last;
        if (own < 0) begin
            if (r == 2'b11)  o_own = 1 - last;
            else if (r0)     o_own = 0;
            else if (r1)     o_own = 1;
            if (o_own >= 0) o_last = o_own;
        end else begin
            nb = beats + ((r[own] && rdy) ? 1 : 0);
            if (r[own] && nb < b) begin
                o_beats = nb;
            end else begin
                o_beats = 0;
                if (r[1-own])    o_own = 1 - own;
                else if (r[own]) o_own = own;
                else             o_own = -1;
                if (o_own >= 0) o_last = o_own;
            end
        end
    endfunction

    function automatic logic [3:0] mexp(input int own, input bit r0, input bit r1, input bit rdy);
        bit [1:0] r;
        r = {r1, r0};
        return {own == 1, (own >= 0) && r[own], (own == 0) && rdy, (own == 1) && rdy};
    endfunction

    function automatic int qat(input bit q[$], input int i);
        if (i < q.size()) return int'(q[i]);
        return 2;
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            n_own[k] = 0; n_beats[k] = 0; n_last[k] = 0;
            mstep(m_own[k], m_beats[k], m_last[k], req_0, req_1, out_ready, burst_of[k],
                  n_own[k], n_beats[k], n_last[k]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_own[k] <= -1; m_beats[k] <= 0; m_last[k] <= 1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_own[k] <= n_own[k]; m_beats[k] <= n_beats[k]; m_last[k] <= n_last[k];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outs_A", dut_out[0], 4'b0000);
            check("reset_outs_B", dut_out[1], 4'b0000);
        end else begin
            check("cycle_outs_A", dut_out[0], mexp(m_own[0], req_0, req_1, out_ready));
            check("cycle_outs_B", dut_out[1], mexp(m_own[1], req_0, req_1, out_ready));
            if (a_ov && out_ready) logA.push_back(a_sel);
            if (b_ov && out_ready) logB.push_back(b_sel);
        end
    end

    task automatic drive(input bit r0, input bit r1, input bit rdy, input int n);
        req_0 = r0; req_1 = r1; out_ready = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        logA.delete();
        logB.delete();
    endtask

    initial begin
        rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0; out_ready = 1'b1;
        do_reset();

        // Both requesting: four beats per source, alternating; BURST=1 toggles every beat.
        drive(1, 1, 1, 17);
        check("t1_countA", logA.size(), 16);
        for (int i = 0; i < 8; i++) check("t1_orderA", qat(logA, i), (i < 4) ? 0 : 1);
        check("t1_countB", logB.size(), 16);
        for (int i = 0; i < 8; i++) check("t1_orderB", qat(logB, i), i % 2);

        // Only source 1: continuous re-grant, sel stays 1.
        do_reset();
        drive(0, 1, 1, 10);
        check("t2_count", logA.size(), 9);
        check("t2_ones", logA.sum() with (int'(item)), 9);

        // Source 0 drops after two beats; its return waits for source 1's burst.
        do_reset();
        drive(1, 1, 1, 3);
        drive(0, 1, 1, 1);
        check("t3_sel_after_drop", a_sel, 1'b1);
        drive(1, 1, 1, 5);
        check("t3_count", logA.size(), 7);
        check("t3_beat1", qat(logA, 1), 0);
        check("t3_beat2", qat(logA, 2), 1);
        check("t3_beat5", qat(logA, 5), 1);
        check("t3_beat6", qat(logA, 6), 0);

        // Downstream stall for three cycles mid-burst.
        do_reset();
        drive(1, 0, 1, 3);
        drive(1, 0, 0, 3);
        check("t4_stall_ready0", a_r0, 1'b0);
        check("t4_stall_valid", a_ov, 1'b1);
        check("t4_stall_count", logA.size(), 2);
        drive(1, 0, 1, 2);
        check("t4_count", logA.size(), 4);
        check("t4_sel", a_sel, 1'b0);

        // Asynchronous reset at beat 2 of a source-1 grant.
        do_reset();
        drive(0, 1, 1, 3);
        check("t5_sel_pre", a_sel, 1'b1);
        check("t5_valid_pre", a_ov, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_outs", {a_sel, a_ov, a_r0, a_r1}, 4'b0000);
        req_0 = 1'b1; req_1 = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        logA.delete();
        logB.delete();
        drive(1, 1, 1, 3);
        check("t5_count", logA.size(), 2);
        check("t5_first_src", qat(logA, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
